// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: a direct-mapped table of 2-bit
// saturating counters indexed by PC. It predicts conditional branches in IF,
// carries the prediction to EX, trains on the resolved outcome and counts
// mispredictions.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_inst,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        stall,
    input  logic        flush,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        br_actual,
    output logic        br_prediction,
    output logic [15:0] mispredict_count
);

    logic [1:0]       ctr [ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             is_br;
    logic [12:0]      b_imm;
    logic [1:0]       wr_cur;
    logic [1:0]       wr_next;
    logic             pred_id;
    logic             pred_ex;
    logic             unused_bits;

    assign rd_idx = fetch_pc[IDX_W+1:2];
    assign wr_idx = update_pc[IDX_W+1:2];
    assign is_br  = (fetch_inst[6:0] == 7'b1100011);
    assign b_imm  = {fetch_inst[31], fetch_inst[7], fetch_inst[30:25], fetch_inst[11:8], 1'b0};

    // PC bits outside the index and the instruction fields the B-type decode ignores
    assign unused_bits = ^{update_pc[31:IDX_W+2], update_pc[1:0], fetch_inst[24:12]};

    // Combinational IF prediction and target; the table read sees pre-update contents
    always_comb begin
        pred_taken  = is_br & ctr[rd_idx][1];
        pred_target = fetch_pc + {{19{b_imm[12]}}, b_imm};
    end

    // Saturating increment/decrement of the entry addressed by the resolving branch
    always_comb begin
        wr_cur  = ctr[wr_idx];
        wr_next = wr_cur;
        if (br_actual) begin
            if (wr_cur != 2'b11) wr_next = wr_cur + 2'd1;
        end else begin
            if (wr_cur != 2'b00) wr_next = wr_cur - 2'd1;
        end
    end

    // Counter table: reset to weakly not-taken, one entry trained per resolving branch
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr[i[IDX_W-1:0]] <= 2'b01;
            end
        end else if (update_en) begin
            ctr[wr_idx] <= wr_next;
        end
    end

    // IF/ID and ID/EX prediction registers; flush wins over stall
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pred_id <= 1'b0;
            pred_ex <= 1'b0;
        end else if (!stall) begin
            pred_id <= pred_taken;
            pred_ex <= pred_id;
        end
    end

    assign br_prediction = pred_ex;

    // Saturating misprediction counter, compared against the prediction aligned in EX
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_count <= '0;
        end else if (update_en && (br_actual != pred_ex) && (mispredict_count != '1)) begin
            mispredict_count <= mispredict_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the counter table and pipeline.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam logic [31:0] ADD_INST = 32'h0020_80B3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall;
    logic        flush;
    logic        update_en;
    logic [31:0] update_pc;
    logic        br_actual;
    logic        br_prediction;
    logic [15:0] mispredict_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_ctr [ENTRIES];
    bit m_id;
    bit m_ex;
    int m_cnt;

    // Last combinational outputs observed before an edge
    logic        last_pt;
    logic [31:0] last_tgt;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .fetch_inst       (fetch_inst),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .stall            (stall),
        .flush            (flush),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .br_actual        (br_actual),
        .br_prediction    (br_prediction),
        .mispredict_count (mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic int entry(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit model_taken();
        return (fetch_inst[6:0] == 7'b1100011) && (m_ctr[entry(fetch_pc)] >= 2);
    endfunction

    function automatic logic [31:0] model_target();
        int imm;
        imm = fetch_inst[31] ? -4096 : 0;
        imm += int'(fetch_inst[7]) * 2048 + int'(fetch_inst[30:25]) * 32 + int'(fetch_inst[11:8]) * 2;
        return fetch_pc + imm;
    endfunction

    function automatic logic [31:0] mk_b(input int imm, input logic [2:0] f3);
        logic [12:0] b;
        b = imm[12:0];
        return {b[12], b[10:5], 5'd2, 5'd1, f3, b[4:1], b[11], 7'b1100011};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic ue,
                         input logic [31:0] upc, input logic act, input logic st, input logic fl);
        rst        = 1'b0;
        fetch_pc   = pc;
        fetch_inst = inst;
        update_en  = ue;
        update_pc  = upc;
        br_actual  = act;
        stall      = st;
        flush      = fl;
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs
    task automatic tick();
        bit pt;
        int wi;
        #2;
        pt       = model_taken();
        last_pt  = pred_taken;
        last_tgt = pred_target;
        check("pred_taken", pred_taken, pt);
        check("pred_target", pred_target, model_target());
        @(posedge clk);
        if (rst) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_id  = 0;
            m_ex  = 0;
            m_cnt = 0;
        end else begin
            if (update_en) begin
                wi = entry(update_pc);
                if ((br_actual != m_ex) && (m_cnt < 65535)) m_cnt++;
                if (br_actual) m_ctr[wi] = (m_ctr[wi] < 3) ? m_ctr[wi] + 1 : 3;
                else           m_ctr[wi] = (m_ctr[wi] > 0) ? m_ctr[wi] - 1 : 0;
            end
            if (flush) begin
                m_id = 0;
                m_ex = 0;
            end else if (!stall) begin
                m_ex = m_id;
                m_id = pt;
            end
        end
        #1;
        check("br_prediction", br_prediction, m_ex);
        check("mispredict_count", mispredict_count, m_cnt);
    endtask

    initial begin
        logic [31:0] beq;
        logic [31:0] bne;
        beq = mk_b(16, 3'b000);
        bne = mk_b(-8, 3'b001);
        foreach (m_ctr[i]) m_ctr[i] = 1;
        m_id = 0;
        m_ex = 0;
        m_cnt = 0;

        drive(32'h100, beq, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // Reset state
        drive(32'h100, beq, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("reset_pred_taken", last_pt, 0);
        tick();
        check("reset_br_prediction", br_prediction, 0);
        check("reset_count", mispredict_count, 0);

        // Counter saturation at 0x100: 01->10->11->11
        for (int i = 0; i < 4; i++) begin
            drive(32'h100, beq, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
            tick();
            check("sat_pred_taken", last_pt, (i >= 1) ? 1 : 0);
        end
        check("sat_mispredicts", mispredict_count, 3);

        // Target computation and non-branch suppression
        drive(32'h200, bne, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bne_target", last_tgt, 32'h1F8);
        drive(32'h100, ADD_INST, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("add_not_taken", last_pt, 0);

        // Stall delays the taken prediction by exactly 3 cycles
        drive(32'h100, beq, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(32'h100, ADD_INST, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            tick();
            check("stall_hold", br_prediction, 0);
        end
        drive(32'h100, ADD_INST, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("stall_release", br_prediction, 1);

        // Flush together with stall clears both registers
        drive(32'h100, beq, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("pre_flush", br_prediction, 1);
        drive(32'h100, ADD_INST, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        check("flush_ex", br_prediction, 0);
        drive(32'h100, ADD_INST, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("flush_id", br_prediction, 0);

        // Aliasing of 0x004 and 0x104, same-cycle read sees old value
        drive(32'h004, beq, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("alias_before", last_pt, 0);
        drive(32'h004, beq, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
        tick();
        check("same_cycle_old", last_pt, 0);
        drive(32'h004, beq, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("alias_after", last_pt, 1);

        // Drive the misprediction counter into saturation
        drive(32'h100, ADD_INST, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) tick();
        check("count_saturated", mispredict_count, 32'hFFFF);

        // Reset pulse mid-operation
        rst = 1'b1;
        tick();
        check("rst_pulse_count", mispredict_count, 0);
        for (int i = 0; i < ENTRIES; i++) begin
            drive(32'(i * 4), beq, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            tick();
            check("rst_pulse_ctr", last_pt, 0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] inst;
            inst = ($urandom_range(0, 1) == 1)
                 ? mk_b(int'($urandom_range(0, 8191)) - 4096, 3'($urandom_range(0, 7)))
                 : $urandom;
            drive($urandom & 32'hFFFF_F03C, inst, 1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_F03C, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
